button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter width_p, default 3, number of independent button channels (>=1).
REQ-002 Parameter debounce_cycles_p, default 4096, consecutive stable cycles required to accept a new level (>=1).
REQ-003 Parameter active_low_p, default 0, 1 = raw input is 0 when pressed (inverted before synchronisation).
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 btn_async_unsafe_i  input  width_p  raw button inputs: asynchronous to clk_i and not debounced.
REQ-007 level_o  output  width_p  debounced pressed state, 1 = pressed.
REQ-008 press_o  output  width_p  one-cycle pulse per accepted 0->1 level transition.
REQ-009 release_o  output  width_p  one-cycle pulse per accepted 1->0 level transition.
REQ-010 toggle_o  output  width_p  flips once per accepted press.

Function
REQ-011 Each channel shall be fully independent: no shared counters and no cross-channel interaction.
REQ-012 Each channel shall apply polarity inversion when active_low_p=1 and then pass the input through a 2-flop synchroniser; the second flop output is s.
REQ-013 Each channel shall hold a counter of width $clog2(debounce_cycles_p+1) that cannot overflow.
REQ-014 Stable-cycle counting: any cycle with s==level_o shall clear the counter to 0.
REQ-015 Stable-cycle counting: any cycle with s!=level_o and counter<debounce_cycles_p-1 shall increment the counter.
REQ-016 Acceptance: in a cycle with s!=level_o and counter==debounce_cycles_p-1, the next edge shall set level_o to s and clear the counter.
REQ-017 Latency: a clean input step shall reach level_o exactly 2+debounce_cycles_p edges after the first edge that samples the new raw value.
REQ-018 Any glitch in which s returns to level_o before acceptance shall restart the count from 0, and level_o shall not change.
REQ-019 press_o shall be 1 exactly during the first cycle in which level_o=1 after having been 0.
REQ-020 release_o shall be 1 exactly during the first cycle in which level_o=0 after having been 1.
REQ-021 press_o and release_o shall never both be 1 on the same channel in the same cycle.
REQ-022 toggle_o shall invert on the same edge that raises press_o, and shall be unaffected by releases.
REQ-023 With debounce_cycles_p=1, a single-cycle difference on s shall be accepted: 3 edges from raw change to level_o.
REQ-024 All outputs shall be registered, with no combinational path from btn_async_unsafe_i to any output.

Reset
REQ-025 While reset_i=1 at an edge, synchroniser flops, counters, level_o, press_o, release_o and toggle_o shall all become 0.
REQ-026 Synchroniser flops shall reset to 0 post-inversion, i.e. "not pressed" regardless of active_low_p.
REQ-027 Reset mid-count shall discard the partial count.
REQ-028 After reset, a button held throughout reset shall be accepted 2+debounce_cycles_p edges after reset_i falls, producing one press_o pulse.
REQ-029 Reset shall take priority over every other update in the same cycle.

Structure
REQ-030 Shared package button_pkg shall hold the default debounce constant and a localparam function giving the counter width.
REQ-031 A per-channel sub-module, button_channel, shall contain the synchroniser, counter, level, pulse and toggle logic.
REQ-032 button_conditioner shall instantiate width_p copies of button_channel in a generate loop.

Verification (width_p=3, debounce_cycles_p=4, active_low_p=0 unless stated)
REQ-033 Reset behaviour: hold ch0 raw=1 during 5 reset cycles, release reset -> level_o[0] rises at edge 6 post-reset; press_o[0]=1 for 1 cycle; toggle_o[0]=1.
REQ-034 Clean press/release: ch1 0->1, hold 20 cycles, then 1->0 -> level_o[1] rises 6 edges after the raw change; exactly 1 press_o pulse and 1 release_o pulse; toggle_o[1] stays 1.
REQ-035 Bounce rejection: ch2 raw pattern 1,1,1,0,1,1,1,0 repeating -> level_o[2] stays 0 and no pulses occur; then hold 1 -> accepted after 6 edges.
REQ-036 Channel independence and polarity: active_low_p=1, all raw=1 -> all outputs 0; drive raw[1]=0 -> only channel 1 presses; simultaneous press on ch0 and release on ch1 -> independent pulses in the same cycle.
REQ-037 Reset mid-count: raw=1 for 3 cycles post-sync, then reset_i=1 for 1 cycle -> counter 0, no press; full 6 edges required again after reset.
REQ-038 Minimum debounce: debounce_cycles_p=1, single-cycle raw pulse on ch0 -> level_o[0] high for 1 cycle, press_o and release_o on consecutive cycles, toggle_o[0]=1.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants and types for the button conditioner: default debounce
// length, counter sizing and the per-channel event bundle.
package button_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4096;
  localparam int SYNC_STAGES             = 2;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic toggle;
  } btn_evt_t;

  // Counter holds at most cycles-1, so this width leaves headroom and never wraps.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: polarity fix, 2-flop synchroniser, stable-cycle
// debounce counter, registered level plus press/release pulses and toggle.
module button_channel
  import button_pkg::*;
#(
  parameter int debounce_cycles_p = DEBOUNCE_CYCLES_DEFAULT,
  parameter int active_low_p      = 0
) (
  input  logic     clk_i,
  input  logic     reset_i,
  input  logic     btn_async_unsafe_i,
  output btn_evt_t evt_o
);

  localparam int             CW   = cnt_width(debounce_cycles_p);
  localparam logic [CW-1:0]  LAST = CW'(debounce_cycles_p - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_rel;
  logic                   r_toggle;

  logic w_raw;
  logic w_s;
  logic w_diff;
  logic w_accept;

  // Inverting ahead of the synchroniser makes reset value 0 mean "not pressed".
  assign w_raw    = (active_low_p != 0) ? ~btn_async_unsafe_i : btn_async_unsafe_i;
  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_diff   = (w_s != r_level);
  assign w_accept = w_diff && (r_cnt == LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_press  <= 1'b0;
      r_rel    <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      if (!w_diff || w_accept) r_cnt <= '0;
      else                     r_cnt <= r_cnt + 1'b1;

      if (w_accept) r_level <= w_s;
      r_press <= w_accept &  w_s;
      r_rel   <= w_accept & ~w_s;
      if (w_accept && w_s) r_toggle <= ~r_toggle;
    end
  end

  assign evt_o.level  = r_level;
  assign evt_o.press  = r_press;
  assign evt_o.rel    = r_rel;
  assign evt_o.toggle = r_toggle;

endmodule

// File: rtl/button_conditioner.sv
// Array of independent debounced button channels; each output bit comes
// straight from a channel register.
module button_conditioner
  import button_pkg::*;
#(
  parameter int width_p           = 3,
  parameter int debounce_cycles_p = DEBOUNCE_CYCLES_DEFAULT,
  parameter int active_low_p      = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] btn_async_unsafe_i,
  output logic [width_p-1:0] level_o,
  output logic [width_p-1:0] press_o,
  output logic [width_p-1:0] release_o,
  output logic [width_p-1:0] toggle_o
);

  btn_evt_t w_evt [width_p];

  for (genvar g = 0; g < width_p; g++) begin : g_ch
    button_channel #(
      .debounce_cycles_p (debounce_cycles_p),
      .active_low_p      (active_low_p)
    ) u_ch (
      .clk_i              (clk_i),
      .reset_i            (reset_i),
      .btn_async_unsafe_i (btn_async_unsafe_i[g]),
      .evt_o              (w_evt[g])
    );

    assign level_o[g]   = w_evt[g].level;
    assign press_o[g]   = w_evt[g].press;
    assign release_o[g] = w_evt[g].rel;
    assign toggle_o[g]  = w_evt[g].toggle;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: three conditioner instances (default polarity D=4,
// active-low D=4, D=1) driven from vector tables and short sequences.
module tb_button_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic [2:0] raw_a, raw_b, raw_c;
  logic [2:0] lv_a, pr_a, rl_a, tg_a;
  logic [2:0] lv_b, pr_b, rl_b, tg_b;
  logic [2:0] lv_c, pr_c, rl_c, tg_c;

  button_conditioner #(.width_p(3), .debounce_cycles_p(4), .active_low_p(0)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .btn_async_unsafe_i(raw_a),
    .level_o(lv_a), .press_o(pr_a), .release_o(rl_a), .toggle_o(tg_a));

  button_conditioner #(.width_p(3), .debounce_cycles_p(4), .active_low_p(1)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .btn_async_unsafe_i(raw_b),
    .level_o(lv_b), .press_o(pr_b), .release_o(rl_b), .toggle_o(tg_b));

  button_conditioner #(.width_p(3), .debounce_cycles_p(1), .active_low_p(0)) dut_c (
    .clk_i(clk), .reset_i(rst_c), .btn_async_unsafe_i(raw_c),
    .level_o(lv_c), .press_o(pr_c), .release_o(rl_c), .toggle_o(tg_c));

  typedef struct {
    int         n;
    logic       rst;
    logic [2:0] raw;
    logic [2:0] l, p, r, t;
    string      nm;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Drive one DUT's inputs, take one edge, then compare its outputs.
  task automatic step(input int sel, input logic rst, input logic [2:0] raw,
                      input logic [2:0] l, input logic [2:0] p,
                      input logic [2:0] r, input logic [2:0] t, input string nm);
    logic [11:0] act;
    case (sel)
      0:       begin rst_a = rst; raw_a = raw; end
      1:       begin rst_b = rst; raw_b = raw; end
      default: begin rst_c = rst; raw_c = raw; end
    endcase
    @(posedge clk);
    #1;
    case (sel)
      0:       act = {lv_a, pr_a, rl_a, tg_a};
      1:       act = {lv_b, pr_b, rl_b, tg_b};
      default: act = {lv_c, pr_c, rl_c, tg_c};
    endcase
    checks++;
    if (act !== {l, p, r, t}) begin
      errors++;
      $display("FAIL %s @%0t: got lvl=%b prs=%b rel=%b tog=%b want lvl=%b prs=%b rel=%b tog=%b",
               nm, $time, act[11:9], act[8:6], act[5:3], act[2:0], l, p, r, t);
    end
    checks++;
    if ((act[8:6] & act[5:3]) != 3'b000) begin
      errors++;
      $display("FAIL %s_excl @%0t: press=%b release=%b overlap, want none",
               nm, $time, act[8:6], act[5:3]);
    end
  endtask

  vec_t tbl[$];

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    raw_a = '0;   raw_b = 3'b111; raw_c = '0;

    //          n  rst raw     lvl     prs     rel     tog
    tbl.push_back('{5, 1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, "rst_hold"});
    tbl.push_back('{5, 0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, "rst_wait"});
    tbl.push_back('{1, 0, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001, "rst_accept"});
    tbl.push_back('{2, 0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, "rst_settle"});
    tbl.push_back('{5, 0, 3'b011, 3'b001, 3'b000, 3'b000, 3'b001, "ch1_wait"});
    tbl.push_back('{1, 0, 3'b011, 3'b011, 3'b010, 3'b000, 3'b011, "ch1_press"});
    tbl.push_back('{14,0, 3'b011, 3'b011, 3'b000, 3'b000, 3'b011, "ch1_hold"});
    tbl.push_back('{5, 0, 3'b001, 3'b011, 3'b000, 3'b000, 3'b011, "ch1_relwait"});
    tbl.push_back('{1, 0, 3'b001, 3'b001, 3'b000, 3'b010, 3'b011, "ch1_release"});
    tbl.push_back('{3, 0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b011, "ch1_idle"});
    for (int k = 0; k < 4; k++) begin
      tbl.push_back('{3, 0, 3'b101, 3'b001, 3'b000, 3'b000, 3'b011, "bounce_hi"});
      tbl.push_back('{1, 0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b011, "bounce_lo"});
    end
    tbl.push_back('{5, 0, 3'b101, 3'b001, 3'b000, 3'b000, 3'b011, "ch2_wait"});
    tbl.push_back('{1, 0, 3'b101, 3'b101, 3'b100, 3'b000, 3'b111, "ch2_press"});
    tbl.push_back('{2, 0, 3'b101, 3'b101, 3'b000, 3'b000, 3'b111, "ch2_hold"});
    // Reset lands on the edge that would otherwise accept.
    tbl.push_back('{2, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, "mid_rst0"});
    tbl.push_back('{5, 0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, "mid_count"});
    tbl.push_back('{1, 1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, "mid_rst1"});
    tbl.push_back('{5, 0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, "mid_recount"});
    tbl.push_back('{1, 0, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001, "mid_accept"});

    foreach (tbl[i])
      for (int j = 0; j < tbl[i].n; j++)
        step(0, tbl[i].rst, tbl[i].raw, tbl[i].l, tbl[i].p, tbl[i].r, tbl[i].t, tbl[i].nm);

    // Active-low: raw 1 = released. Press ch1, then press ch0 / release ch1 together.
    for (int j = 0; j < 2; j++)  step(1, 1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, "al_rst");
    for (int j = 0; j < 10; j++) step(1, 0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, "al_idle");
    for (int j = 0; j < 5; j++)  step(1, 0, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, "al_wait1");
    step(1, 0, 3'b101, 3'b010, 3'b010, 3'b000, 3'b010, "al_press1");
    for (int j = 0; j < 2; j++)  step(1, 0, 3'b101, 3'b010, 3'b000, 3'b000, 3'b010, "al_hold1");
    for (int j = 0; j < 5; j++)  step(1, 0, 3'b110, 3'b010, 3'b000, 3'b000, 3'b010, "al_wait2");
    step(1, 0, 3'b110, 3'b001, 3'b001, 3'b010, 3'b011, "al_swap");
    step(1, 0, 3'b110, 3'b001, 3'b000, 3'b000, 3'b011, "al_after");

    // Minimum debounce: one-cycle raw pulse is accepted and then released.
    for (int j = 0; j < 2; j++) step(2, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, "d1_rst");
    step(2, 0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, "d1_e1");
    step(2, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, "d1_e2");
    step(2, 0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001, "d1_e3");
    step(2, 0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, "d1_e4");
    step(2, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, "d1_e5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
